// File: rtl/wave_dac_spi.sv
// wave_dac_spi: gain/saturate 16-bit wave samples and serialise each one as a
// 24-bit SPI frame {CMD, code} to an external DAC. SPI mode 0, MSB first.
//
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   sample_in/valid/ready        valid/ready sample input into a one-entry buffer
//   gain                         9-bit unsigned gain, 256 = unity, taken at frame load
//   dac_sclk/dac_mosi/dac_cs_n   SPI outputs
//   frame_done                   one-cycle pulse as cs_n returns high
//   frame_count                  number of completed frames (wraps)
module wave_dac_spi #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  CMD     = 8'h30,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [8:0]  gain,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_cs_n,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W  = $clog2(CS_GAP + 1);
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned FRM_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               ready_q, ready_d;
  logic [FRM_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic [24:0]        product_c;
  logic [16:0]        prod_hi_c;
  logic [15:0]        scaled_c;

  // Gain multiply with saturation: anything at or above 2^24 clips to full scale.
  always_comb begin
    product_c = 25'(buf_q) * 25'(gain);
    prod_hi_c = 17'(product_c >> 8);
    scaled_c  = prod_hi_c[16] ? 16'hFFFF : prod_hi_c[15:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    sclk_d        = sclk_q;
    cs_n_d        = cs_n_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    // ready_q mirrors !buf_full_q, so an accept never coincides with a release.
    if (sample_valid && ready_q) begin
      buf_d      = sample_in;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (buf_full_d) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        shift_d    = {CMD, scaled_c};
        buf_full_d = 1'b0;
        bit_cnt_d  = BIT_W'(FRM_W - 1);
        div_cnt_d  = '0;
        sclk_d     = 1'b0;
        cs_n_d     = 1'b0;
        state_d    = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of a high phase: either advance to the next bit or close the frame.
            sclk_d = 1'b0;
            if (bit_cnt_q == '0) begin
              cs_n_d        = 1'b1;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              gap_cnt_d     = GAP_W'(1);
              state_d       = ST_GAP;
            end else begin
              shift_d   = {shift_q[FRM_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q - BIT_W'(1);
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        // The frame_done cycle is the first of the CS_GAP high cycles.
        if (gap_cnt_q == GAP_W'(CS_GAP)) begin
          state_d = buf_full_d ? ST_LOAD : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = !buf_full_d;
    mosi_d  = cs_n_d ? 1'b0 : shift_d[FRM_W-1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      ready_q       <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      ready_q       <= ready_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
      cs_n_q        <= cs_n_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sample_ready = ready_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign dac_cs_n     = cs_n_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_wave_dac_spi.sv
// Self-checking bench for wave_dac_spi: table of single-frame vectors plus
// hand-written sequences for back-to-back, mid-frame reset, gain change and
// frame_count wrap. A negedge monitor decodes SPI frames into queues.
module tb_wave_dac_spi;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_GAP  = 4;
  localparam int unsigned LOW_CYC = 48 * CLK_DIV;
  localparam int unsigned PERIOD  = LOW_CYC + CS_GAP + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [8:0]  gain;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        dac_cs_n;
  logic        frame_done;
  logic [15:0] frame_count;

  wave_dac_spi #(.CLK_DIV(CLK_DIV), .CMD(8'h30), .CS_GAP(CS_GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .gain         (gain),
    .dac_sclk     (dac_sclk),
    .dac_mosi     (dac_mosi),
    .dac_cs_n     (dac_cs_n),
    .frame_done   (frame_done),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- SPI monitor (samples on negedge) ----------------
  int          cyc = 0;
  int          cur_low = 0;
  int          cur_rises = 0;
  logic [23:0] cur_bits = '0;
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  logic [23:0] frame_q[$];
  int          low_q[$];
  int          rise_q[$];
  int          start_q[$];
  int          end_q[$];
  int          n_starts = 0;
  int          n_done = 0;
  int          proto_err = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dac_cs_n === 1'b0) begin
      if (prev_cs_n) begin
        cur_bits  = '0;
        cur_rises = 0;
        cur_low   = 0;
        start_q.push_back(cyc);
        n_starts  = n_starts + 1;
      end
      cur_low = cur_low + 1;
      if (dac_sclk && !prev_sclk) begin
        cur_bits  = {cur_bits[22:0], dac_mosi};
        cur_rises = cur_rises + 1;
      end
      // mosi may only move when sclk falls
      if (!prev_cs_n && (dac_mosi !== prev_mosi) && !(prev_sclk && !dac_sclk))
        proto_err = proto_err + 1;
    end else if (dac_cs_n === 1'b1) begin
      if (dac_sclk !== 1'b0 || dac_mosi !== 1'b0) proto_err = proto_err + 1;
      if (!prev_cs_n) begin
        frame_q.push_back(cur_bits);
        low_q.push_back(cur_low);
        rise_q.push_back(cur_rises);
        end_q.push_back(cyc);
        cur_rises = 0;
      end
    end
    if (frame_done === 1'b1) begin
      n_done = n_done + 1;
      if (!(dac_cs_n === 1'b1 && !prev_cs_n)) proto_err = proto_err + 1;
    end
    prev_cs_n = (dac_cs_n === 1'b0) ? 1'b0 : 1'b1;
    prev_sclk = (dac_sclk === 1'b1);
    prev_mosi = (dac_mosi === 1'b1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush();
    frame_q.delete();
    low_q.delete();
    rise_q.delete();
    start_q.delete();
    end_q.delete();
  endtask

  task automatic idle_wait();
    repeat (CS_GAP + 3) @(negedge clk);
  endtask

  // Present a sample and return at the negedge just after it is accepted.
  task automatic send(input logic [15:0] d);
    int t = 0;
    sample_in    = d;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("send_timeout", 32'(sample_ready), 32'd1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frame_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (frame_q.size() < n) check("frame_timeout", 32'(frame_q.size()), 32'(n));
  endtask

  task automatic check_frame(input string name, input logic [23:0] exp);
    logic [23:0] got;
    int lo, ri;
    got = 'x; lo = -1; ri = -1;
    if (frame_q.size() > 0) got = frame_q.pop_front();
    if (low_q.size() > 0)   lo  = low_q.pop_front();
    if (rise_q.size() > 0)  ri  = rise_q.pop_front();
    check({name, "_data"},  32'(got), 32'(exp));
    check({name, "_low"},   32'(lo),  32'(LOW_CYC));
    check({name, "_rises"}, 32'(ri),  32'd24);
  endtask

  typedef struct {
    logic [15:0] sample;
    logic [8:0]  gain;
    logic [23:0] frame;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] exp_count;
  int          exp_done;
  int          starts_at_rst;
  int          done_at_rst;
  int          gap;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hABCD, 9'd256, 24'h30ABCD};
    vecs[1] = '{16'h8000, 9'd128, 24'h304000};
    vecs[2] = '{16'hFFFF, 9'd511, 24'h30FFFF};
    vecs[3] = '{16'h1234, 9'd0,   24'h300000};
    vecs[4] = '{16'hFFFF, 9'd256, 24'h30FFFF};
    vecs[5] = '{16'hFFFF, 9'd257, 24'h30FFFF};
    vecs[6] = '{16'h8000, 9'd511, 24'h30FF80};
    vecs[7] = '{16'h0100, 9'd257, 24'h300101};
    vecs[8] = '{16'h4000, 9'd300, 24'h304B00};

    rst = 1'b1; sample_in = '0; sample_valid = 1'b0; gain = 9'd256;
    exp_count = '0; exp_done = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk",  32'(dac_sclk),     32'd0);
    check("rst_mosi",  32'(dac_mosi),     32'd0);
    check("rst_cs_n",  32'(dac_cs_n),     32'd1);
    check("rst_done",  32'(frame_done),   32'd0);
    check("rst_count", 32'(frame_count),  32'd0);
    check("rst_ready", 32'(sample_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(sample_ready), 32'd1);

    // Single-frame vectors, each started from IDLE
    foreach (vecs[i]) begin
      idle_wait();
      flush();
      gain = vecs[i].gain;
      send(vecs[i].sample);
      check($sformatf("v%0d_load_cs_n", i), 32'(dac_cs_n),     32'd1);
      check($sformatf("v%0d_full",      i), 32'(sample_ready), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_start_cs_n", i), 32'(dac_cs_n), 32'd0);
      wait_frames(1);
      exp_count = exp_count + 16'd1;
      exp_done++;
      check_frame($sformatf("v%0d", i), vecs[i].frame);
      check($sformatf("v%0d_count", i), 32'(frame_count), 32'(exp_count));
    end

    // Back-to-back samples with valid held high
    idle_wait();
    flush();
    gain = 9'd256;
    send(16'd1);
    send(16'd2);
    check("b2b_ready_full", 32'(sample_ready), 32'd0);
    send(16'd3);
    wait_frames(3);
    exp_count = exp_count + 16'd3;
    exp_done += 3;
    if (start_q.size() >= 3 && end_q.size() >= 2) begin
      check("b2b_spacing01", 32'(start_q[1] - start_q[0]), 32'(PERIOD));
      check("b2b_spacing12", 32'(start_q[2] - start_q[1]), 32'(PERIOD));
      gap = start_q[1] - end_q[0];
      check("b2b_gap_min", 32'(gap >= int'(CS_GAP)), 32'd1);
    end else begin
      check("b2b_starts", 32'(start_q.size()), 32'd3);
    end
    check_frame("b2b_f1", 24'h300001);
    check_frame("b2b_f2", 24'h300002);
    check_frame("b2b_f3", 24'h300003);
    repeat (PERIOD + 10) @(negedge clk);
    check("b2b_no_extra", 32'(frame_q.size()), 32'd0);
    check("b2b_count", 32'(frame_count), 32'(exp_count));

    // Reset in mid-frame with a sample buffered
    idle_wait();
    flush();
    send(16'h5A5A);
    send(16'h0F0F);
    begin
      int t = 0;
      while (cur_rises < 10 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) check("rst_mid_timeout", 32'(cur_rises), 32'd10);
    end
    starts_at_rst = n_starts;
    done_at_rst   = n_done;
    rst = 1'b1;
    @(negedge clk);
    check("rmid_cs_n",  32'(dac_cs_n),     32'd1);
    check("rmid_sclk",  32'(dac_sclk),     32'd0);
    check("rmid_mosi",  32'(dac_mosi),     32'd0);
    check("rmid_done",  32'(frame_done),   32'd0);
    check("rmid_count", 32'(frame_count),  32'd0);
    check("rmid_ready", 32'(sample_ready), 32'd0);
    rst = 1'b0;
    exp_count = '0;
    @(negedge clk);
    check("rmid_ready_rel", 32'(sample_ready), 32'd1);
    repeat (300) @(negedge clk);
    check("rmid_no_start", 32'(n_starts), 32'(starts_at_rst));
    check("rmid_no_done",  32'(n_done),   32'(done_at_rst));
    check("rmid_count2",   32'(frame_count), 32'(exp_count));
    flush();

    // Gain change mid-frame
    idle_wait();
    flush();
    gain = 9'd256;
    send(16'h1234);
    begin
      int t = 0;
      while (cur_rises < 5 && t < 1000) begin
        @(negedge clk);
        t++;
      end
    end
    gain = 9'd64;
    send(16'h1234);
    wait_frames(2);
    exp_count = exp_count + 16'd2;
    exp_done += 2;
    check_frame("gain_f1", 24'h301234);
    check_frame("gain_f2", 24'h30048D);
    check("gain_count", 32'(frame_count), 32'(exp_count));

    // frame_count wrap
    idle_wait();
    flush();
    force dut.frame_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    check("wrap_preload", 32'(frame_count), 32'h0000FFFE);
    gain = 9'd256;
    send(16'h0001);
    wait_frames(1);
    exp_done++;
    check_frame("wrap_f1", 24'h300001);
    check("wrap_ffff", 32'(frame_count), 32'h0000FFFF);
    idle_wait();
    send(16'h0002);
    wait_frames(1);
    exp_done++;
    check_frame("wrap_f2", 24'h300002);
    check("wrap_zero", 32'(frame_count), 32'h00000000);

    idle_wait();
    check("done_pulses", 32'(n_done),    32'(exp_done));
    check("protocol",    32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
